// File: rtl/note_sequence_game.sv
// rtl/note_sequence_game.sv - note-sequence memory game: plays a growing prefix, then checks the player's answers
// Optional feature: define NSG_TIMEOUT_EN to add a WAIT_ANS answer timeout of TIMEOUT_TICKS ticks.
module note_sequence_game #(
  parameter int NOTE_W        = 4,
  parameter int DEPTH         = 8,
  parameter int START_LEN     = 3,
  parameter int TICK_DIV      = 5000000,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NOTE_W*DEPTH-1:0]      seq_in,
  input  logic                         seq_load,
  input  logic [NOTE_W-1:0]            answer,
  input  logic                         answer_valid,
  output logic [NOTE_W-1:0]            piezo_out,
  output logic [NOTE_W-1:0]            led_out,
  output logic [2:0]                   state_out,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         miss,
  output logic                         round_pass,
  output logic                         game_done
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAY_ON  = 3'd1,
    PLAY_OFF = 3'd2,
    WAIT_ANS = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                   state;
  logic [NOTE_W*DEPTH-1:0]  seq;
  logic [IW-1:0]            idx;
  logic [IW-1:0]            idx_next;
  logic [CW-1:0]            tick_cnt;
  logic [NOTE_W-1:0]        notes [DEPTH];
  logic                     tick;
  logic                     last;
  logic                     hit;
  logic                     timeout;

  for (genvar k = 0; k < DEPTH; k++) begin : g_note
    assign notes[k] = seq[k*NOTE_W +: NOTE_W];
  end

  assign tick      = (tick_cnt == CW'(TICK_DIV - 1));
  assign last      = (LW'(idx) == level - LW'(1));
  assign idx_next  = idx + 1'b1;
  assign hit       = (answer == notes[idx]);
  assign state_out = state;

`ifdef NSG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] to_cnt;
  assign timeout = tick && (to_cnt == TW'(TIMEOUT_TICKS - 1));
`else
  assign timeout = 1'b0;
  // TIMEOUT_TICKS only matters when the timeout is built in.
  if (TIMEOUT_TICKS < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      seq        <= '0;
      idx        <= '0;
      tick_cnt   <= '0;
      level      <= '0;
      piezo_out  <= '0;
      led_out    <= '0;
      miss       <= 1'b0;
      round_pass <= 1'b0;
      game_done  <= 1'b0;
`ifdef NSG_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      miss       <= 1'b0;
      round_pass <= 1'b0;
      if (enable) begin
        if (seq_load) begin
          seq       <= seq_in;
          level     <= LW'(START_LEN);
          idx       <= '0;
          tick_cnt  <= '0;
          game_done <= 1'b0;
          state     <= PLAY_ON;
          piezo_out <= seq_in[NOTE_W-1:0];
          led_out   <= seq_in[NOTE_W-1:0];
        end else begin
          case (state)
            PLAY_ON: begin
              if (tick) begin
                tick_cnt  <= '0;
                state     <= PLAY_OFF;
                piezo_out <= '0;
                led_out   <= '0;
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
            PLAY_OFF: begin
              if (tick) begin
                tick_cnt <= '0;
                if (!last) begin
                  idx       <= idx_next;
                  state     <= PLAY_ON;
                  piezo_out <= notes[idx_next];
                  led_out   <= notes[idx_next];
                end else begin
                  idx   <= '0;
                  state <= WAIT_ANS;
`ifdef NSG_TIMEOUT_EN
                  to_cnt <= '0;
`endif
                end
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
            WAIT_ANS: begin
              if ((answer_valid && !hit) || (!answer_valid && timeout)) begin
                miss      <= 1'b1;
                idx       <= '0;
                tick_cnt  <= '0;
                state     <= PLAY_ON;
                piezo_out <= notes[0];
                led_out   <= notes[0];
              end else if (answer_valid) begin
                tick_cnt <= '0;
`ifdef NSG_TIMEOUT_EN
                to_cnt   <= '0;
`endif
                if (!last) begin
                  idx     <= idx_next;
                  led_out <= answer;
                end else if (level < LW'(DEPTH)) begin
                  round_pass <= 1'b1;
                  level      <= level + 1'b1;
                  idx        <= '0;
                  state      <= PLAY_ON;
                  piezo_out  <= notes[0];
                  led_out    <= notes[0];
                end else begin
                  round_pass <= 1'b1;
                  game_done  <= 1'b1;
                  idx        <= '0;
                  state      <= DONE;
                  piezo_out  <= '0;
                  led_out    <= '0;
                end
              end else begin
`ifdef NSG_TIMEOUT_EN
                if (tick) begin
                  tick_cnt <= '0;
                  to_cnt   <= to_cnt + 1'b1;
                end else begin
                  tick_cnt <= tick_cnt + 1'b1;
                end
`endif
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: doc/note_sequence_game.md
# note_sequence_game

Parametrised note-sequence memory game engine: loads a packed sequence of notes, plays a growing prefix on the piezo/LED outputs at a tick-paced rate, then checks the player's answers note by note. A correct round lengthens the prefix by one note until the full sequence is passed. A mismatch replays the same prefix. It sits between the keypad/answer decoder and the piezo/LED drivers, gated by the turn-arbitration `enable` signal.

## Interface
- `NOTE_W`, 4: bits per note; note value 0 means silence.
- `DEPTH`, 8: notes in the sequence (≥2).
- `START_LEN`, 3: first-round prefix length (1..DEPTH).
- `TICK_DIV`, 5000000: clk cycles per tick (≥2).
- `TIMEOUT_TICKS`, 10: answer timeout in ticks; used only with `NSG_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  player turn; low freezes all state, including the tick counter.
- `seq_in`  in  NOTE_W*DEPTH  packed notes; note k is `seq_in[k*NOTE_W +: NOTE_W]`.
- `seq_load`  in  1  one-cycle strobe: capture `seq_in` and start a game.
- `answer`  in  NOTE_W  player note.
- `answer_valid`  in  1  one-cycle strobe qualifying `answer`.
- `piezo_out`  out  NOTE_W  note to sound; 0 means silent.
- `led_out`  out  NOTE_W  LED pattern.
- `state_out`  out  3  FSM state code.
- `level`  out  $clog2(DEPTH+1)  current prefix length.
- `miss`  out  1  one-cycle pulse on a wrong answer or timeout.
- `round_pass`  out  1  one-cycle pulse when a prefix is completed.
- `game_done`  out  1  level-held flag: full sequence passed.

## Operation
- States and codes: IDLE=0, PLAY_ON=1, PLAY_OFF=2, WAIT_ANS=3, DONE=4.
- Reset values:
  - State IDLE; all outputs 0; `level`=0.
  - Sequence register 0; `idx`=0; tick counter 0.
- `seq_load` (any state, `enable` high):
  - capture `seq_in`; `level`=START_LEN; `idx`=0; clear tick counter and `game_done`.
  - go to PLAY_ON.
  - `seq_load` has priority over every other event in the same cycle.
- PLAY_ON: `piezo_out`=`led_out`=note[`idx`]. On tick, go to PLAY_OFF.
- PLAY_OFF: outputs 0. On tick:
  - if `idx`<`level`-1: `idx`++ and go to PLAY_ON;
  - else: `idx`=0 and go to WAIT_ANS.
- WAIT_ANS: `piezo_out`=0; `led_out` shows the last accepted `answer`. On `answer_valid`:
  - `answer`≠note[`idx`]: pulse `miss`; `idx`=0; go to PLAY_ON. `level` is unchanged.
  - match and `idx`<`level`-1: `idx`++.
  - match and `idx`=`level`-1, `level`<DEPTH: pulse `round_pass`; `level`++; `idx`=0; go to PLAY_ON.
  - match and `idx`=`level`-1, `level`=DEPTH: pulse `round_pass`; set `game_done`; go to DONE.
- `answer_valid` is ignored outside WAIT_ANS.
- DONE: outputs 0; remains until `seq_load` or reset.
- `enable` low: no state, counter or output changes; strobes are ignored.

## Timing
- Tick counter:
  - counts 0..TICK_DIV-1; the tick fires in the cycle the count equals TICK_DIV-1;
  - the counter is cleared on every state transition, so each PLAY phase lasts exactly TICK_DIV enabled cycles.
- All outputs are registered. An event at edge n is visible after edge n.
- Playback latency:
  - `seq_load` at edge n: note0 appears on `piezo_out` after edge n;
  - `seq_load` to WAIT_ANS takes 2·`level`·TICK_DIV cycles.
- `miss` and `round_pass` are asserted for exactly one cycle, on the same edge as the state change.
- `level` arithmetic saturates at DEPTH; `idx` never exceeds `level`-1.
- Asynchronous reset mid-playback: immediate return to IDLE with outputs 0; no pulse is emitted.

## Configuration
- `NSG_TIMEOUT_EN` defined:
  - WAIT_ANS counts ticks from entry, and restarts the count on each accepted answer;
  - at TIMEOUT_TICKS ticks without an answer, behave exactly as a mismatch (`miss` pulse, replay of the same `level`).
- Undefined: WAIT_ANS waits indefinitely, and no timeout counter is synthesised.

## Test plan
Bench parameters: DEPTH=4, START_LEN=2, TICK_DIV=4, `seq_in`=16'h4321, `enable`=1.

- Load → `piezo_out` sequence 1(4 cycles), 0(4), 2(4), 0(4); then `state_out`=3, `level`=2.
- Answers 1, 2 → `round_pass` single pulse; `level`=3; replay 1, 2, 3.
- Answers 1, 5 at `level`=3 → `miss` pulse on the 5; `level` stays 3; replay starts with note 1.
- Correct rounds through `level`=4, then answers 1, 2, 3, 4 → `round_pass`; `game_done`=1; `state_out`=4; outputs 0.
- `enable` low for 10 cycles mid-PLAY_ON → `piezo_out` held; phase resumes with the remaining cycles. Reset mid-PLAY_OFF → all outputs 0 at once; `seq_load` together with `answer_valid` → load wins and `level`=2.
- With `NSG_TIMEOUT_EN` and TIMEOUT_TICKS=3: no answer for 12 cycles in WAIT_ANS → `miss` pulse and replay at the same `level`.
